// File: rtl/arm_pkg.sv
// Shared fetch-stage types: address/instruction widths, fetch FSM states and
// the prefetch FIFO entry layout.
package arm_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and decode: synchronous FIFO
// with push/pop/flush, occupancy count and a combinational head entry.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fifo_entry_t       wdata,
  output logic [CNT_W-1:0]  count,
  output fifo_entry_t       head
);

  fifo_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the stage gates its outputs with valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a
// time and buffers {instr, pc+4}. FETCH_STATS_EN adds fetch/drop counters.
//
// state | meaning
// IDLE  | no request outstanding; issue next cycle if the buffer has room
// REQ   | request to fetch_pc outstanding; response is pushed on ack
// DROP  | request outstanding after a redirect; response is discarded on ack
module if_fetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [15:0]       stat_dropped
`endif
);

  import arm_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] branch_target;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop;
  logic              push;
  logic              pop;
  fifo_entry_t       wdata;
  fifo_entry_t       head;

  assign branch_target   = {branch_addr[ADDR_W-1:2], 2'b00};
  assign valid           = (count != '0);
  // A redirect wins over everything: no push, no pop, FIFO flushed.
  assign pop             = valid && !freeze && !branch_taken;
  assign push            = (state == REQ) && imem_ack && !branch_taken;
  assign count_after_pop = count - CNT_W'(pop);
  assign wdata           = '{instr: imem_rdata, pc: fetch_pc + ADDR_W'(4)};
  assign instruction     = valid ? head.instr : '0;
  assign pc              = valid ? head.pc : '0;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      if (branch_taken)                  fetch_pc <= branch_target;
      else if (state == REQ && imem_ack) fetch_pc <= fetch_pc + ADDR_W'(4);
      case (state)
        IDLE: begin
          if (!branch_taken && int'(count_after_pop) < FIFO_DEPTH) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (branch_taken) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic drop_evt;
  assign drop_evt = imem_ack && ((state == DROP) || (state == REQ && branch_taken));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      if (push && stat_fetched != '1)     stat_fetched <= stat_fetched + 32'd1;
      if (drop_evt && stat_dropped != '1) stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a memory model with programmable
// latency and a reference queue of expected {instr, pc} entries.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_dropped;
`endif

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .instruction  (instruction),
    .pc           (pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_dropped (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] addr_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] m_pc = '0;
  logic        m_stale = 1'b0;
  logic [31:0] m_fetched = '0;
  logic [15:0] m_dropped = '0;
  int          lat = 0;
  int          cnt = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hE3A0_0000;
  endfunction

  // Reference model, updated from the inputs the DUT sees at the same edge.
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_pc = '0;
      m_stale = 1'b0;
      m_fetched = '0;
      m_dropped = '0;
    end else begin
      if (branch_taken) begin
        if (imem_ack) m_dropped++;
        q.delete();
        m_pc = {branch_addr[31:2], 2'b00};
      end else begin
        if (!freeze && q.size() != 0) void'(q.pop_front());
        if (imem_ack) begin
          if (m_stale) m_dropped++;
          else begin
            q.push_back('{instr: mem_data(m_pc), pc: m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
            m_fetched++;
          end
        end
      end
      if (imem_ack) m_stale = 1'b0;
      else if (branch_taken && imem_req) m_stale = 1'b1;
    end
  end

  // Output checks and memory responder, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check_val("valid", valid, q.size() != 0);
      if (q.size() != 0) begin
        check_val("instr", instruction, q[0].instr);
        check_val("pc", pc, q[0].pc);
      end
      if (valid && !freeze) pc_log.push_back(pc);
      if (imem_req && !prev_req) begin
        check_val("req_addr", imem_addr, m_pc);
        addr_log.push_back(imem_addr);
      end
      if (imem_req && prev_req) check_val("addr_stable", imem_addr, prev_addr);
      if (imem_req && cnt >= lat) begin
        imem_ack = 1'b1;
        imem_rdata = mem_data(imem_addr);
        cnt = 0;
      end else begin
        imem_ack = 1'b0;
        cnt = imem_req ? cnt + 1 : 0;
      end
      prev_req = imem_req;
      prev_addr = imem_addr;
    end else begin
      imem_ack = 1'b0;
      cnt = 0;
      prev_req = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    addr_log.delete();
    pc_log.delete();
    #2 rst = 1'b1;
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_addr = a;
    branch_taken = 1'b1;
    @(negedge clk);
    #1 branch_taken = 1'b0;
  endtask

  initial begin
    int n;
    logic hit;

    // 1: zero-wait memory, free-running
    do_reset();
    lat = 0;
    repeat (20) @(negedge clk);
    #1;
    check_val("t1_nreq", addr_log.size() >= 3, 1);
    if (addr_log.size() >= 3) begin
      check_val("t1_addr0", addr_log[0], 32'h0);
      check_val("t1_addr1", addr_log[1], 32'h4);
      check_val("t1_addr2", addr_log[2], 32'h8);
    end
    check_val("t1_npop", pc_log.size() >= 3, 1);
    if (pc_log.size() >= 3) begin
      check_val("t1_pc0", pc_log[0], 32'h4);
      check_val("t1_pc1", pc_log[1], 32'h8);
      check_val("t1_pc2", pc_log[2], 32'hC);
    end

    // 2: latency 3 with freeze held until the buffer fills
    do_reset();
    lat = 3;
    freeze = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = (q.size() == 2);
      n++;
    end
    check_val("t2_fill", hit, 1);
    repeat (6) begin
      @(negedge clk);
      #1;
      check_val("t2_req_idle", imem_req, 0);
      check_val("t2_valid", valid, 1);
      check_val("t2_pc_hold", pc, 32'h4);
    end
    freeze = 1'b0;
    @(negedge clk);
    #1;
    check_val("t2_pop1_valid", valid, 1);
    check_val("t2_pop1_pc", pc, 32'h8);
    @(negedge clk);
    #1;
    check_val("t2_drained", valid, 0);

    // 3: redirect while a request to 0x8 is waiting
    do_reset();
    lat = 3;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = imem_req && (imem_addr == 32'h8) && !imem_ack;
      n++;
    end
    check_val("t3_req8", hit, 1);
    do_branch(32'h100);
    check_val("t3_valid_after_br", valid, 0);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = valid;
      n++;
    end
    check_val("t3_refill", hit, 1);
    check_val("t3_pc", pc, 32'h104);
    check_val("t3_instr", instruction, mem_data(32'h100));

    // 4: redirect coinciding with ack, one entry buffered, freeze held
    do_reset();
    lat = 2;
    freeze = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = (q.size() == 1) && imem_ack;
      n++;
    end
    check_val("t4_ack_one", hit, 1);
    do_branch(32'h202);
    check_val("t4_flushed", valid, 0);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = imem_req;
      n++;
    end
    check_val("t4_req", hit, 1);
    check_val("t4_addr", imem_addr, 32'h200);

    // 5: random freeze, latency and redirects; pops coincide with acks
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      freeze = ($urandom_range(0, 3) == 0);
      lat = $urandom_range(0, 2);
      if ($urandom_range(0, 39) == 0) begin
        branch_addr = $urandom;
        branch_taken = 1'b1;
      end else begin
        branch_taken = 1'b0;
      end
    end
    @(negedge clk);
    #1 branch_taken = 1'b0;
`ifdef FETCH_STATS_EN
    check_val("t5_stat_fetched", stat_fetched, m_fetched);
    check_val("t5_stat_dropped", stat_dropped, m_dropped);
`endif

    // 6: asynchronous reset in the middle of a request
    do_reset();
    lat = 3;
    freeze = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 hit = (q.size() == 1) && imem_req;
      n++;
    end
    check_val("t6_busy", hit, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("t6_req", imem_req, 0);
    check_val("t6_valid", valid, 0);
    check_val("t6_addr", imem_addr, 32'h0);
    check_val("t6_instr", instruction, 32'h0);
    check_val("t6_pc", pc, 32'h0);
`ifdef FETCH_STATS_EN
    check_val("t6_stat_fetched", stat_fetched, 32'h0);
    check_val("t6_stat_dropped", stat_dropped, 16'h0);
`endif
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
